// File: rtl/thread_scheduler_if.sv
// Control/issue bundle between the control registers, the scheduler and the IP file.
// The master drives start/halt/wait/hold; the slave (scheduler) returns the issue slot and run state.
interface thread_scheduler_if #(
  parameter int unsigned WAIT_W = 8
);
  logic              start_valid;
  logic [3:0]        start_mask;
  logic              halt_valid;
  logic [1:0]        halt_tid;
  logic              wait_valid;
  logic [1:0]        wait_tid;
  logic [WAIT_W-1:0] wait_cycles;
  logic              hold;
  logic [1:0]        tid;
  logic              en;
  logic [7:0]        thr_state;
  logic              all_idle;

  modport master (
    output start_valid, start_mask, halt_valid, halt_tid,
    output wait_valid, wait_tid, wait_cycles, hold,
    input  tid, en, thr_state, all_idle
  );

  modport slave (
    input  start_valid, start_mask, halt_valid, halt_tid,
    input  wait_valid, wait_tid, wait_cycles, hold,
    output tid, en, thr_state, all_idle
  );
endinterface

// File: rtl/thread_scheduler.sv
// Barrel-CPU issue scheduler: picks one of 4 threads per cycle, round robin from rr_ptr,
// honouring per-thread run/wait state and a minimum re-issue gap.
module thread_scheduler #(
  parameter int unsigned MIN_GAP = 4,
  parameter int unsigned WAIT_W  = 8
) (
  input logic               clk,
  input logic               rst_n,
  thread_scheduler_if.slave bus
);

  localparam int unsigned NTHR  = 4;
  localparam int unsigned TID_W = 2;
  localparam int unsigned GAP_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_WAIT = 2'b10
  } thr_st_e;

  thr_st_e            state_q [NTHR];
  thr_st_e            state_d [NTHR];
  logic [WAIT_W-1:0]  wcnt_q  [NTHR];
  logic [WAIT_W-1:0]  wcnt_d  [NTHR];
  logic [GAP_W-1:0]   gap_q   [NTHR];
  logic [GAP_W-1:0]   gap_d   [NTHR];
  logic [TID_W-1:0]   rr_q, rr_d;
  logic [TID_W-1:0]   tid_q, tid_d;
  logic               en_q, en_d;

  logic [NTHR-1:0]    halt_hit;
  logic [NTHR-1:0]    wait_hit;
  logic [NTHR-1:0]    elig;
  logic [TID_W-1:0]   cand;
  logic [TID_W-1:0]   sel;
  logic               found;

  // State register: thread FSMs, wait/gap counters, round-robin pointer and issue slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NTHR; t++) begin
        state_q[t] <= ST_IDLE;
        wcnt_q[t]  <= '0;
        gap_q[t]   <= GAP_W'(MIN_GAP);
      end
      rr_q  <= '0;
      tid_q <= '0;
      en_q  <= 1'b0;
    end else begin
      for (int t = 0; t < NTHR; t++) begin
        state_q[t] <= state_d[t];
        wcnt_q[t]  <= wcnt_d[t];
        gap_q[t]   <= gap_d[t];
      end
      rr_q  <= rr_d;
      tid_q <= tid_d;
      en_q  <= en_d;
    end
  end

  // Next state: per-thread FSM (halt > wait > start), eligibility, selection, gap update
  always_comb begin
    for (int t = 0; t < NTHR; t++) begin
      state_d[t] = state_q[t];
      wcnt_d[t]  = wcnt_q[t];
      gap_d[t]   = gap_q[t];
    end
    rr_d     = rr_q;
    tid_d    = tid_q;
    en_d     = 1'b0;
    halt_hit = '0;
    wait_hit = '0;
    elig     = '0;
    cand     = '0;
    sel      = '0;
    found    = 1'b0;

    for (int t = 0; t < NTHR; t++) begin
      halt_hit[t] = bus.halt_valid && (bus.halt_tid == TID_W'(t));
      wait_hit[t] = bus.wait_valid && (bus.wait_tid == TID_W'(t));
      // A same-cycle halt or wait aimed at a thread suppresses its issue
      elig[t] = (state_q[t] == ST_RUN) && (gap_q[t] >= GAP_W'(MIN_GAP)) &&
                !halt_hit[t] && !wait_hit[t];

      if (halt_hit[t]) begin
        state_d[t] = ST_IDLE;
        wcnt_d[t]  = '0;
      end else if (wait_hit[t] && (state_q[t] != ST_IDLE) && (bus.wait_cycles != '0)) begin
        state_d[t] = ST_WAIT;
        wcnt_d[t]  = bus.wait_cycles;
      end else begin
        case (state_q[t])
          ST_IDLE: if (bus.start_valid && bus.start_mask[t]) state_d[t] = ST_RUN;
          ST_WAIT: begin
            wcnt_d[t] = wcnt_q[t] - WAIT_W'(1);
            if (wcnt_q[t] == WAIT_W'(1)) state_d[t] = ST_RUN;
          end
          default: ;
        endcase
      end
    end

    for (int i = 0; i < NTHR; i++) begin
      cand = rr_q + TID_W'(i);
      if (!found && elig[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end

    // Hold freezes the issue slot, pointer and gaps; FSMs above still advance
    if (!bus.hold) begin
      for (int t = 0; t < NTHR; t++) begin
        if (gap_q[t] < GAP_W'(MIN_GAP)) gap_d[t] = gap_q[t] + GAP_W'(1);
      end
      if (found) begin
        tid_d      = sel;
        en_d       = 1'b1;
        rr_d       = sel + TID_W'(1);
        gap_d[sel] = GAP_W'(1);
      end
    end
  end

  assign bus.tid       = tid_q;
  assign bus.en        = en_q;
  assign bus.thr_state = {state_q[3], state_q[2], state_q[1], state_q[0]};
  assign bus.all_idle  = (state_q[0] == ST_IDLE) && (state_q[1] == ST_IDLE) &&
                         (state_q[2] == ST_IDLE) && (state_q[3] == ST_IDLE);

endmodule

// File: tb/tb_thread_scheduler.sv
// Scoreboard bench for thread_scheduler: expected issue slots are queued when stimulus is
// driven and popped each cycle against the DUT (MIN_GAP=4 main instance, MIN_GAP=2 second).
`timescale 1ns/1ps
module tb_thread_scheduler;
  localparam int unsigned WAIT_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  thread_scheduler_if #(.WAIT_W(WAIT_W)) bus  ();
  thread_scheduler_if #(.WAIT_W(WAIT_W)) bus2 ();

  thread_scheduler #(.MIN_GAP(4), .WAIT_W(WAIT_W)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  thread_scheduler #(.MIN_GAP(2), .WAIT_W(WAIT_W)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct {
    logic       en;
    logic [1:0] tid;
  } exp_t;

  exp_t exp_q [$];
  exp_t exp2_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.start_valid  = 1'b0; bus.start_mask  = 4'h0;
    bus.halt_valid   = 1'b0; bus.halt_tid    = 2'd0;
    bus.wait_valid   = 1'b0; bus.wait_tid    = 2'd0;
    bus.wait_cycles  = '0;   bus.hold        = 1'b0;
    bus2.start_valid = 1'b0; bus2.start_mask = 4'h0;
    bus2.halt_valid  = 1'b0; bus2.halt_tid   = 2'd0;
    bus2.wait_valid  = 1'b0; bus2.wait_tid   = 2'd0;
    bus2.wait_cycles = '0;   bus2.hold       = 1'b0;
  endtask

  task automatic push(input int which, input logic en, input logic [1:0] tid);
    exp_t e;
    e.en  = en;
    e.tid = tid;
    if (which == 0) exp_q.push_back(e);
    else            exp2_q.push_back(e);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    int   k;
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) tick();
    checks++; if (bus.en !== 1'b0) begin errors++; $display("FAIL reset_en got=%0b exp=0", bus.en); end
    checks++; if (bus.tid !== 2'd0) begin errors++; $display("FAIL reset_tid got=%0d exp=0", bus.tid); end
    checks++; if (bus.thr_state !== 8'h00) begin errors++; $display("FAIL reset_state got=%h exp=00", bus.thr_state); end
    checks++; if (bus.all_idle !== 1'b1) begin errors++; $display("FAIL reset_all_idle got=%0b exp=1", bus.all_idle); end
    rst_n = 1'b1;
    repeat (3) push(0, 1'b0, 2'd0);
    k = 0;
    while (exp_q.size() > 0) begin
      tick(); k++;
      e = exp_q.pop_front();
      checks++;
      if (bus.en !== e.en) begin
        errors++; $display("FAIL reset_no_issue k=%0d en=%0b exp=%0b", k, bus.en, e.en);
      end
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    int   k;
    do_reset();
    bus.start_valid = 1'b1; bus.start_mask = 4'hF;
    push(0, 1'b0, 2'd0);
    for (int i = 0; i < 9; i++) push(0, 1'b1, 2'(i % 4));
    k = 0;
    while (exp_q.size() > 0) begin
      tick(); k++;
      e = exp_q.pop_front();
      checks++;
      if (bus.en !== e.en || (e.en && bus.tid !== e.tid)) begin
        errors++; $display("FAIL rr_issue k=%0d en=%0b tid=%0d exp en=%0b tid=%0d", k, bus.en, bus.tid, e.en, e.tid);
      end
      if (k == 1) begin
        clear_inputs();
        checks++; if (bus.thr_state !== 8'h55) begin errors++; $display("FAIL rr_state got=%h exp=55", bus.thr_state); end
        checks++; if (bus.all_idle !== 1'b0) begin errors++; $display("FAIL rr_all_idle got=%0b exp=0", bus.all_idle); end
      end
    end
  endtask

  task automatic test_single_thread();
    exp_t e, e2;
    int   k;
    do_reset();
    bus.start_valid  = 1'b1; bus.start_mask  = 4'b0100;
    bus2.start_valid = 1'b1; bus2.start_mask = 4'b0100;
    push(0, 1'b0, 2'd0);
    push(1, 1'b0, 2'd0);
    for (int i = 0; i < 9; i++) begin
      push(0, (i % 4) == 0, 2'd2);
      push(1, (i % 2) == 0, 2'd2);
    end
    k = 0;
    while (exp_q.size() > 0) begin
      tick(); k++;
      if (k == 1) clear_inputs();
      e  = exp_q.pop_front();
      e2 = exp2_q.pop_front();
      checks++;
      if (bus.en !== e.en || (e.en && bus.tid !== e.tid)) begin
        errors++; $display("FAIL single_gap4 k=%0d en=%0b tid=%0d exp en=%0b tid=%0d", k, bus.en, bus.tid, e.en, e.tid);
      end
      checks++;
      if (bus2.en !== e2.en || (e2.en && bus2.tid !== e2.tid)) begin
        errors++; $display("FAIL single_gap2 k=%0d en=%0b tid=%0d exp en=%0b tid=%0d", k, bus2.en, bus2.tid, e2.en, e2.tid);
      end
    end
  endtask

  task automatic test_wait();
    exp_t e;
    int   k;
    logic [1:0] seq [15];
    logic       ens [15];
    seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd2, 2'd3, 2'd0, 2'd0, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    ens = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    bus.start_valid = 1'b1; bus.start_mask = 4'hF;
    push(0, 1'b0, 2'd0);
    for (int i = 0; i < 15; i++) push(0, ens[i], seq[i]);
    k = 0;
    while (exp_q.size() > 0) begin
      tick(); k++;
      e = exp_q.pop_front();
      checks++;
      if (bus.en !== e.en || (e.en && bus.tid !== e.tid)) begin
        errors++; $display("FAIL wait_issue k=%0d en=%0b tid=%0d exp en=%0b tid=%0d", k, bus.en, bus.tid, e.en, e.tid);
      end
      if (k == 1) clear_inputs();
      if (k == 6) begin
        bus.wait_valid = 1'b1; bus.wait_tid = 2'd1; bus.wait_cycles = WAIT_W'(5);
      end
      if (k == 7) begin
        clear_inputs();
        checks++; if (bus.thr_state !== 8'h59) begin errors++; $display("FAIL wait_enter got=%h exp=59", bus.thr_state); end
      end
      if (k == 11) begin
        checks++; if (bus.thr_state !== 8'h59) begin errors++; $display("FAIL wait_still got=%h exp=59", bus.thr_state); end
      end
      if (k == 12) begin
        checks++; if (bus.thr_state !== 8'h55) begin errors++; $display("FAIL wait_expire got=%h exp=55", bus.thr_state); end
      end
    end
  endtask

  task automatic test_halt();
    exp_t e;
    int   k;
    do_reset();
    bus.start_valid = 1'b1; bus.start_mask = 4'b1010;
    bus.halt_valid  = 1'b1; bus.halt_tid   = 2'd3;
    push(0, 1'b0, 2'd0);
    push(0, 1'b1, 2'd1);
    repeat (3) push(0, 1'b0, 2'd0);
    push(0, 1'b1, 2'd1);
    repeat (4) push(0, 1'b0, 2'd0);
    k = 0;
    while (exp_q.size() > 0) begin
      tick(); k++;
      e = exp_q.pop_front();
      checks++;
      if (bus.en !== e.en || (e.en && bus.tid !== e.tid)) begin
        errors++; $display("FAIL halt_issue k=%0d en=%0b tid=%0d exp en=%0b tid=%0d", k, bus.en, bus.tid, e.en, e.tid);
      end
      if (k == 1) begin
        clear_inputs();
        checks++; if (bus.thr_state !== 8'h04) begin errors++; $display("FAIL halt_beats_start got=%h exp=04", bus.thr_state); end
        checks++; if (bus.all_idle !== 1'b0) begin errors++; $display("FAIL halt_all_idle0 got=%0b exp=0", bus.all_idle); end
      end
      if (k == 6) begin
        bus.halt_valid = 1'b1; bus.halt_tid = 2'd1;
      end
      if (k == 7) begin
        clear_inputs();
        checks++; if (bus.all_idle !== 1'b1) begin errors++; $display("FAIL halt_all_idle1 got=%0b exp=1", bus.all_idle); end
        checks++; if (bus.thr_state !== 8'h00) begin errors++; $display("FAIL halt_last got=%h exp=00", bus.thr_state); end
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    int   k;
    logic [1:0] seq [14];
    logic       ens [14];
    seq = '{2'd0, 2'd0, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    ens = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    bus.start_valid = 1'b1; bus.start_mask = 4'hF;
    for (int i = 0; i < 14; i++) push(0, ens[i], seq[i]);
    k = 0;
    while (exp_q.size() > 0) begin
      tick(); k++;
      e = exp_q.pop_front();
      checks++;
      if (bus.en !== e.en || (e.en && bus.tid !== e.tid)) begin
        errors++; $display("FAIL hold_issue k=%0d en=%0b tid=%0d exp en=%0b tid=%0d", k, bus.en, bus.tid, e.en, e.tid);
      end
      if (k == 1) clear_inputs();
      if (k == 3) begin
        bus.wait_valid = 1'b1; bus.wait_tid = 2'd2; bus.wait_cycles = WAIT_W'(3);
      end
      if (k == 4) begin
        bus.wait_valid = 1'b0;
        checks++; if (bus.thr_state !== 8'h65) begin errors++; $display("FAIL hold_wait_enter got=%h exp=65", bus.thr_state); end
      end
      if (k == 5) bus.hold = 1'b1;
      if (k == 6) begin
        checks++; if (bus.thr_state !== 8'h65) begin errors++; $display("FAIL hold_wait_mid got=%h exp=65", bus.thr_state); end
      end
      if (k == 7) begin
        checks++; if (bus.thr_state !== 8'h55) begin errors++; $display("FAIL hold_wait_expire got=%h exp=55", bus.thr_state); end
      end
      if (k == 8) bus.hold = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int   k;
    do_reset();
    bus.start_valid = 1'b1; bus.start_mask = 4'hF;
    tick();
    clear_inputs();
    repeat (3) tick();
    checks++; if (bus.en !== 1'b1) begin errors++; $display("FAIL areset_pre_en got=%0b exp=1", bus.en); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.en !== 1'b0) begin errors++; $display("FAIL areset_en got=%0b exp=0", bus.en); end
    checks++; if (bus.tid !== 2'd0) begin errors++; $display("FAIL areset_tid got=%0d exp=0", bus.tid); end
    checks++; if (bus.thr_state !== 8'h00) begin errors++; $display("FAIL areset_state got=%h exp=00", bus.thr_state); end
    checks++; if (bus.all_idle !== 1'b1) begin errors++; $display("FAIL areset_all_idle got=%0b exp=1", bus.all_idle); end
    tick();
    rst_n = 1'b1;
    repeat (5) push(0, 1'b0, 2'd0);
    k = 0;
    while (exp_q.size() > 0) begin
      tick(); k++;
      e = exp_q.pop_front();
      checks++;
      if (bus.en !== e.en) begin
        errors++; $display("FAIL areset_idle k=%0d en=%0b exp=%0b", k, bus.en, e.en);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single_thread();
    test_wait();
    test_halt();
    test_hold();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
